lpc_algorithm_done_pio: RTL and testbench
=========================================

# lpc_algorithm_done_pio

Avalon-MM slave input port that returns the LPC core's status to the Nios II host: the counterpart of the write-only run-control output register. It samples a `WIDTH`-bit status bus (e.g. "algorithm done") through a synchronizer and latches selected edges into a sticky edge-capture register. It raises a level interrupt through a per-bit mask and exposes the data, mask and capture registers on a 2-bit-address slave with registered readdata.

## Interface

Parameters:
- `WIDTH`, 1: width of `in_port` and of every register; 1..32.
- `EDGE_TYPE`, 0: edges to capture. 0 = rising, 1 = falling, 2 = any.
- `SYNC_STAGES`, 2: synchronizer flops on `in_port`; 2..3.

Ports:
- `clk`  in  1  single system clock; all logic on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `address`  in  2  register select, word offset.
- `chipselect`  in  1  slave select.
- `write_n`  in  1  0 = write, 1 = read when `chipselect` is high.
- `writedata`  in  32  write data; bits above `WIDTH` are ignored.
- `in_port`  in  WIDTH  asynchronous status inputs.
- `readdata`  out  32  registered read data; bits above `WIDTH` read 0.
- `irq`  out  1  level interrupt, active high.

## Operation

- Register map:
  - Offset 0 DATA: read-only; returns the synchronized input `sync`. Writes are ignored.
  - Offset 1: reserved; reads 0, writes ignored.
  - Offset 2 IRQMASK: read/write; `WIDTH` bits.
  - Offset 3 EDGECAP: read; a write clears each bit where `writedata` is 1 (W1C). A bit written 0 is unchanged.
- Synchronizer: a chain of `SYNC_STAGES` flops on `in_port`; the last stage is `sync`. Register `sync_d` holds `sync` delayed one cycle.
- Edge detect, per bit:
  - rise = `sync & ~sync_d`
  - fall = `~sync & sync_d`
  - Selected by `EDGE_TYPE`.
- EDGECAP update, per bit, each cycle: `cap <= (cap & ~clr) | edge`.
  - `clr` is the W1C write mask.
  - Set wins over a clear in the same cycle.
  - Bits stay set until explicitly cleared.
- `irq = |(EDGECAP & IRQMASK)`, combinational from the registers, with no extra flop.
- Read access: `chipselect & write_n`. `readdata` is loaded from the selected register at that clock edge. It holds its value otherwise and has no read side effects.
- Write access: `chipselect & ~write_n`. It takes effect at that clock edge. No wait states; the slave never stalls.
- Reset (async, `reset_n` = 0) clears:
  - All synchronizer flops and `sync_d`.
  - IRQMASK and EDGECAP.
  - `readdata`; `irq` is therefore 0.
  - Reset mid-operation discards any pending edge.
  - First cycle after release: `sync_d` = 0. A `sync` that is already high therefore produces one rising edge (and one "any" edge) after the synchronizer fills. This is intended: it reports an already-done condition.

## Timing

- `in_port` change settling before edge k:
  - `sync` updates at edge k+`SYNC_STAGES`-1.
  - EDGECAP bit sets at edge k+`SYNC_STAGES`.
  - `irq` is valid right after that edge when masked in.
- With the default `SYNC_STAGES`=2: EDGECAP sets at k+2.
- Read latency is 1. Address is presented with read asserted at edge n; `readdata` is valid after edge n and held until the next read.
- Write to IRQMASK at edge n: `irq` reflects the new mask after edge n.
- W1C at edge n: the bit and `irq` drop after edge n, unless a new edge lands in the same cycle.
- A read of EDGECAP at edge n returns the value before that edge's update.
- Pulses shorter than one `clk` period may be missed; pulses of at least 2 cycles are always captured.

## Test plan

- Reset with `in_port`=0:
  - `readdata`, `irq` = 0.
  - Reads of offsets 0..3 return 0 (readdata appears one cycle after each read).
  - Writing 0xFFFFFFFF to offsets 0 and 1 leaves reads at 0.
- `WIDTH`=1, `EDGE_TYPE`=0: write IRQMASK=1, then drive `in_port` 0->1 before edge k.
  - EDGECAP=1 and `irq`=1 after edge k+2.
  - DATA reads 1.
  - Then drive `in_port` 1->0: EDGECAP stays 1.
- Mask gating: EDGECAP=1, IRQMASK=0, so `irq`=0.
  - Write IRQMASK=1: `irq`=1 the next cycle.
  - Write IRQMASK=0: `irq`=0 the next cycle.
- W1C vs. new edge, `WIDTH`=4, `EDGE_TYPE`=2, EDGECAP=0xF:
  - Write 0x5: reads 0xA.
  - Write 0xA in the same cycle that bit 1's `sync` toggles: reads 0x2.
- Falling edges, `EDGE_TYPE`=1: `in_port` 1->0 on bit 0 sets EDGECAP=0x1; a later 0->1 leaves it unchanged.
- Reset mid-operation: assert `reset_n` low asynchronously with EDGECAP=0x3, IRQMASK=0x3 and `irq`=1.
  - All of them go to 0 immediately.
  - Release with `in_port`=0x1 and `EDGE_TYPE`=0: EDGECAP=0x1 `SYNC_STAGES` cycles later.

Source files
------------

// File: rtl/lpc_algorithm_done_pio.sv
// lpc_algorithm_done_pio
// Avalon-MM input PIO that reports LPC core status (e.g. "algorithm done")
// back to the host. The status bus is synchronized, edges are latched into a
// sticky W1C capture register, and a masked level interrupt is raised.
//
// Ports
//   clk, reset_n        : system clock, async active-low reset
//   address[1:0]        : 0 DATA (ro), 1 reserved, 2 IRQMASK (rw), 3 EDGECAP (r/W1C)
//   chipselect, write_n : read = cs & write_n, write = cs & ~write_n
//   writedata[31:0]     : write data, bits above WIDTH ignored
//   in_port[WIDTH-1:0]  : asynchronous status inputs
//   readdata[31:0]      : registered read data, one-cycle latency
//   irq                 : |(EDGECAP & IRQMASK), combinational from registers
module lpc_algorithm_done_pio #(
  parameter int WIDTH       = 1,
  parameter int EDGE_TYPE   = 0,  // 0 rising, 1 falling, 2 any
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] sync_w, sync_d_q;
  logic [WIDTH-1:0] edge_w;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] wdata_w, clr_w;
  logic [31:0]      rdata_q, rdata_d;
  logic             rd_en, wr_en;
  logic             unused_wdata;

  assign sync_w  = sync_q[SYNC_STAGES-1];
  assign rd_en   = chipselect & write_n;
  assign wr_en   = chipselect & ~write_n;
  assign wdata_w = writedata[WIDTH-1:0];
  // Upper write bits are architecturally ignored.
  assign unused_wdata = ^writedata;

  generate
    if (EDGE_TYPE == 0) begin : g_rise
      assign edge_w = sync_w & ~sync_d_q;
    end else if (EDGE_TYPE == 1) begin : g_fall
      assign edge_w = ~sync_w & sync_d_q;
    end else begin : g_any
      assign edge_w = sync_w ^ sync_d_q;
    end
  endgenerate

  always_comb begin
    clr_w  = '0;
    mask_d = mask_q;
    if (wr_en && address == 2'd3) clr_w  = wdata_w;
    if (wr_en && address == 2'd2) mask_d = wdata_w;
    // A new edge in the same cycle as a clear keeps the bit set.
    cap_d = (cap_q & ~clr_w) | edge_w;
  end

  // Reads sample the pre-update register values of this edge.
  always_comb begin
    rdata_d = rdata_q;
    if (rd_en) begin
      case (address)
        2'd0:    rdata_d = 32'(sync_w);
        2'd2:    rdata_d = 32'(mask_q);
        2'd3:    rdata_d = 32'(cap_q);
        default: rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q   <= '0;
      sync_d_q <= '0;
      cap_q    <= '0;
      mask_q   <= '0;
      rdata_q  <= '0;
    end else begin
      if (SYNC_STAGES > 1) sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
      else                 sync_q <= in_port;
      sync_d_q <= sync_w;
      cap_q    <= cap_d;
      mask_q   <= mask_d;
      rdata_q  <= rdata_d;
    end
  end

  assign readdata = rdata_q;
  assign irq      = |(cap_q & mask_q);

endmodule

// File: tb/tb_lpc_algorithm_done_pio.sv
module tb_lpc_algorithm_done_pio;
  logic        clk = 0;
  logic        reset_n = 0;
  logic [1:0]  addr = '0;
  logic        wn = 1'b1;
  logic [31:0] wdata = '0;
  logic [3:0]  cs = '0;
  logic [0:0]  in_a = '0;
  logic [3:0]  in_b = '0;
  logic [3:0]  in_c = '0;
  logic [1:0]  in_d = '0;
  logic [31:0] rd [4];
  logic        irqv [4];

  int n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  // A: W1 rising; B: W4 any; C: W4 falling, 3-stage sync; D: W2 rising
  lpc_algorithm_done_pio #(.WIDTH(1), .EDGE_TYPE(0), .SYNC_STAGES(2)) u_a (
    .clk(clk), .reset_n(reset_n), .address(addr), .chipselect(cs[0]), .write_n(wn),
    .writedata(wdata), .in_port(in_a), .readdata(rd[0]), .irq(irqv[0]));
  lpc_algorithm_done_pio #(.WIDTH(4), .EDGE_TYPE(2), .SYNC_STAGES(2)) u_b (
    .clk(clk), .reset_n(reset_n), .address(addr), .chipselect(cs[1]), .write_n(wn),
    .writedata(wdata), .in_port(in_b), .readdata(rd[1]), .irq(irqv[1]));
  lpc_algorithm_done_pio #(.WIDTH(4), .EDGE_TYPE(1), .SYNC_STAGES(3)) u_c (
    .clk(clk), .reset_n(reset_n), .address(addr), .chipselect(cs[2]), .write_n(wn),
    .writedata(wdata), .in_port(in_c), .readdata(rd[2]), .irq(irqv[2]));
  lpc_algorithm_done_pio #(.WIDTH(2), .EDGE_TYPE(0), .SYNC_STAGES(2)) u_d (
    .clk(clk), .reset_n(reset_n), .address(addr), .chipselect(cs[3]), .write_n(wn),
    .writedata(wdata), .in_port(in_d), .readdata(rd[3]), .irq(irqv[3]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic bus(input int d, input logic [1:0] a, input logic wr, input logic [31:0] wd);
    cs = '0; cs[d] = 1'b1; addr = a; wn = ~wr; wdata = wd;
    @(posedge clk); #1;
    cs = '0; wn = 1'b1;
  endtask

  // Assert reset now, hold two edges, release mid-cycle.
  task automatic do_reset();
    reset_n = 0;
    @(posedge clk); @(posedge clk); #3;
    reset_n = 1;
  endtask

  typedef struct {
    logic [1:0]  a;
    logic        wr;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl [12];

  // Random-test model: input history per edge since reset release.
  logic [3:0] hist [0:511];
  function automatic logic [3:0] hv(input int i);
    return (i < 1) ? 4'h0 : hist[i];
  endfunction

  initial begin
    tbl[0]  = '{2'd0, 1'b0, 32'h0,        32'h0};
    tbl[1]  = '{2'd1, 1'b0, 32'h0,        32'h0};
    tbl[2]  = '{2'd2, 1'b0, 32'h0,        32'h0};
    tbl[3]  = '{2'd3, 1'b0, 32'h0,        32'h0};
    tbl[4]  = '{2'd0, 1'b1, 32'hFFFFFFFF, 32'h0};
    tbl[5]  = '{2'd1, 1'b1, 32'hFFFFFFFF, 32'h0};
    tbl[6]  = '{2'd0, 1'b0, 32'h0,        32'h0};
    tbl[7]  = '{2'd1, 1'b0, 32'h0,        32'h0};
    tbl[8]  = '{2'd2, 1'b1, 32'hFFFFFFF9, 32'h0};
    tbl[9]  = '{2'd2, 1'b0, 32'h0,        32'h9};
    tbl[10] = '{2'd2, 1'b1, 32'h0,        32'h0};
    tbl[11] = '{2'd2, 1'b0, 32'h0,        32'h0};

    do_reset();
    #1;
    for (int d = 0; d < 4; d++) begin
      check($sformatf("reset_rd%0d", d), rd[d], 32'h0);
      check($sformatf("reset_irq%0d", d), 32'(irqv[d]), 32'h0);
    end

    // Register map after reset on B.
    for (int i = 0; i < 12; i++) begin
      bus(1, tbl[i].a, tbl[i].wr, tbl[i].wd);
      if (!tbl[i].wr) check($sformatf("tbl%0d_rd", i), rd[1], tbl[i].exp);
      check($sformatf("tbl%0d_irq", i), 32'(irqv[1]), 32'h0);
    end

    // A: rising edge capture and timing.
    bus(0, 2'd2, 1'b1, 32'h1);
    in_a = 1'b1;
    tick(); check("a_irq_k", 32'(irqv[0]), 0);
    tick(); check("a_irq_k1", 32'(irqv[0]), 0);
    tick(); check("a_irq_k2", 32'(irqv[0]), 1);
    bus(0, 2'd0, 1'b0, 0); check("a_data", rd[0], 32'h1);
    bus(0, 2'd3, 1'b0, 0); check("a_cap", rd[0], 32'h1);
    in_a = 1'b0;
    repeat (4) tick();
    bus(0, 2'd3, 1'b0, 0); check("a_cap_after_fall", rd[0], 32'h1);
    bus(0, 2'd0, 1'b0, 0); check("a_data_low", rd[0], 32'h0);
    bus(0, 2'd2, 1'b1, 32'h0); check("a_mask0_irq", 32'(irqv[0]), 0);
    bus(0, 2'd2, 1'b1, 32'h1); check("a_mask1_irq", 32'(irqv[0]), 1);
    bus(0, 2'd2, 1'b1, 32'h0); check("a_mask0b_irq", 32'(irqv[0]), 0);

    // B: W1C vs. simultaneous new edge.
    do_reset();
    in_b = 4'hF;
    repeat (4) tick();
    bus(1, 2'd3, 1'b0, 0); check("b_cap_f", rd[1], 32'hF);
    bus(1, 2'd3, 1'b1, 32'h5);
    bus(1, 2'd3, 1'b0, 0); check("b_w1c5", rd[1], 32'hA);
    in_b = 4'hD;
    tick(); tick();
    bus(1, 2'd3, 1'b1, 32'hA);
    bus(1, 2'd3, 1'b0, 0); check("b_w1c_vs_edge", rd[1], 32'h2);

    // C: falling edges, 3-stage synchronizer.
    in_c = 4'h1;
    do_reset();
    repeat (6) tick();
    bus(2, 2'd2, 1'b1, 32'h1);
    bus(2, 2'd3, 1'b0, 0); check("c_cap_none", rd[2], 32'h0);
    in_c = 4'h0;
    tick(); check("c_irq_k", 32'(irqv[2]), 0);
    tick(); check("c_irq_k1", 32'(irqv[2]), 0);
    tick(); check("c_irq_k2", 32'(irqv[2]), 0);
    tick(); check("c_irq_k3", 32'(irqv[2]), 1);
    bus(2, 2'd3, 1'b0, 0); check("c_cap_fall", rd[2], 32'h1);
    in_c = 4'h1;
    repeat (6) tick();
    bus(2, 2'd3, 1'b0, 0); check("c_cap_rise_ignored", rd[2], 32'h1);

    // D: async reset mid-operation, then already-high input after release.
    in_d = 2'h3;
    do_reset();
    bus(3, 2'd2, 1'b1, 32'h3);
    repeat (4) tick();
    bus(3, 2'd3, 1'b0, 0); check("d_cap3", rd[3], 32'h3);
    check("d_irq_pre", 32'(irqv[3]), 1);
    #2 reset_n = 0;
    #1;
    check("d_irq_async", 32'(irqv[3]), 0);
    check("d_rd_async", rd[3], 32'h0);
    in_d = 2'h1;
    #2 reset_n = 1;
    cs = 4'b1000; addr = 2'd2; wn = 1'b0; wdata = 32'h3;
    @(posedge clk); #1; cs = '0; wn = 1'b1;
    check("d_irq_k", 32'(irqv[3]), 0);
    tick(); check("d_irq_k1", 32'(irqv[3]), 0);
    tick(); check("d_irq_k2", 32'(irqv[3]), 1);
    bus(3, 2'd3, 1'b0, 0); check("d_cap_after_rst", rd[3], 32'h1);

    // B: randomized traffic against a history-based model.
    in_b = 4'h0;
    do_reset();
    begin
      logic [3:0] mcap, mmask, e, clr, data;
      logic [31:0] exp_rd;
      logic        is_rd;
      int          op;
      mcap = '0; mmask = '0;
      for (int t = 1; t <= 400; t++) begin
        if ($urandom_range(3) == 0) in_b = 4'($urandom);
        op = $urandom_range(2);
        addr = 2'($urandom);
        wdata = $urandom;
        cs = (op != 0) ? 4'b0010 : 4'b0000;
        wn = (op != 2);
        @(posedge clk);
        hist[t] = in_b;
        // Registers before this edge: sync = in at edge t-2, prior sync at t-3.
        data  = hv(t - 2);
        e     = hv(t - 2) ^ hv(t - 3);
        is_rd = (op == 1);
        exp_rd = (addr == 2'd0) ? 32'(data) : (addr == 2'd2) ? 32'(mmask) :
                 (addr == 2'd3) ? 32'(mcap) : 32'h0;
        clr = (op == 2 && addr == 2'd3) ? wdata[3:0] : 4'h0;
        if (op == 2 && addr == 2'd2) mmask = wdata[3:0];
        mcap = (mcap & ~clr) | e;
        #1;
        cs = '0; wn = 1'b1;
        check($sformatf("rnd%0d_irq", t), 32'(irqv[1]), 32'(|(mcap & mmask)));
        if (is_rd) check($sformatf("rnd%0d_rd", t), rd[1], exp_rd);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
